// File: rtl/disp_rd_pkg.sv
// Shared definitions for the display frame-buffer read scheduler:
// FSM state encoding and default frame/burst/FIFO geometry.
package disp_rd_pkg;

  localparam int unsigned H_ACTIVE        = 800;
  localparam int unsigned V_ACTIVE        = 480;
  localparam int unsigned DEF_FRAME_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int unsigned DEF_BURST_LEN   = 64;
  localparam int unsigned DEF_FIFO_DEPTH  = 512;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    CHECK,
    REQ,
    WAIT
  } sched_state_t;

endpackage

// File: rtl/disp_frame_rd_sched_if.sv
// DDR3 read-port handshake between the display read scheduler (master)
// and the read arbiter (slave).
interface disp_frame_rd_sched_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LEN_W  = 8
);

  logic              Rd_Req;
  logic [ADDR_W-1:0] Rd_Addr;
  logic [LEN_W-1:0]  Rd_Len;
  logic              Rd_Ack;
  logic              Rd_Done;

  modport master (
    output Rd_Req,
    output Rd_Addr,
    output Rd_Len,
    input  Rd_Ack,
    input  Rd_Done
  );

  modport slave (
    input  Rd_Req,
    input  Rd_Addr,
    input  Rd_Len,
    output Rd_Ack,
    output Rd_Done
  );

endinterface

// File: rtl/disp_rd_addr_gen.sv
// Frame address/remaining-word tracking, next burst length and the
// line-FIFO free-space test for the display read scheduler.
module disp_rd_addr_gen #(
  parameter int unsigned       ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       FRAME_WORDS = 384000,
  parameter int unsigned       BURST_LEN   = 64,
  parameter int unsigned       LEN_W       = 8,
  parameter int unsigned       FIFO_DEPTH  = 512,
  parameter int unsigned       LEVEL_W     = 10
) (
  input  logic               ClkDisp,
  input  logic               Rst_n,
  input  logic               load,
  input  logic               advance,
  input  logic [LEN_W-1:0]   adv_len,
  input  logic [LEVEL_W-1:0] Fifo_Level,
  output logic [ADDR_W-1:0]  addr,
  output logic [LEN_W-1:0]   next_len,
  output logic               remain_zero,
  output logic               space_ok
);

  localparam int unsigned REM_W = $clog2(FRAME_WORDS + 1);
  localparam int unsigned SUM_W = LEVEL_W + 1;

  logic [REM_W-1:0] remain;

  always_ff @(posedge ClkDisp or negedge Rst_n) begin
    if (!Rst_n) begin
      addr   <= BASE_ADDR;
      remain <= '0;
    end else if (load) begin
      addr   <= BASE_ADDR;
      remain <= REM_W'(FRAME_WORDS);
    end else if (advance) begin
      addr   <= addr + ADDR_W'(adv_len);
      remain <= remain - REM_W'(adv_len);
    end
  end

  // Last burst of a frame shrinks to whatever is left.
  always_comb begin
    next_len = LEN_W'(BURST_LEN);
    if (32'(remain) < BURST_LEN) next_len = LEN_W'(remain);
  end

  assign remain_zero = (remain == '0);

  // One extra bit so level + len cannot wrap.
  assign space_ok = (({1'b0, Fifo_Level} + SUM_W'(next_len)) <= SUM_W'(FIFO_DEPTH));

endmodule

// File: rtl/disp_frame_rd_sched.sv
// Display frame-buffer read scheduler: keeps the line FIFO ahead of the display
// with one outstanding DDR3 burst at a time. Optional DISP_UNDERRUN_CNT_EN adds Underrun_Cnt.
module disp_frame_rd_sched
  import disp_rd_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int unsigned       BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned       LEN_W       = 8,
  parameter int unsigned       FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned       LEVEL_W     = 10,
  parameter int unsigned       CLR_CYCLES  = 4
) (
  input  logic                  ClkDisp,
  input  logic                  Rst_n,
  input  logic                  Frame_Begin,
  input  logic [LEVEL_W-1:0]    Fifo_Level,
  input  logic                  Fifo_Empty,
  input  logic                  DataReq,
  disp_frame_rd_sched_if.master rd,
  output logic                  Fifo_Clr,
  output logic                  Frame_Busy
`ifdef DISP_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           Underrun_Cnt
`endif
);

  localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);

  sched_state_t     state, state_nx;
  logic [CLR_W-1:0] clr_cnt;
  logic             pending;
  logic             load, advance, issue;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  next_len;
  logic              remain_zero, space_ok;

  disp_rd_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR),
    .FRAME_WORDS (FRAME_WORDS),
    .BURST_LEN   (BURST_LEN),
    .LEN_W       (LEN_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .LEVEL_W     (LEVEL_W)
  ) u_addr_gen (
    .ClkDisp     (ClkDisp),
    .Rst_n       (Rst_n),
    .load        (load),
    .advance     (advance),
    .adv_len     (rd.Rd_Len),
    .Fifo_Level  (Fifo_Level),
    .addr        (addr),
    .next_len    (next_len),
    .remain_zero (remain_zero),
    .space_ok    (space_ok)
  );

  always_ff @(posedge ClkDisp or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nx;
      clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
      // A new frame start always wins over the clear done by CLEAR.
      if (Frame_Begin)         pending <= 1'b1;
      else if (state == CLEAR) pending <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    advance  = 1'b0;
    issue    = 1'b0;
    case (state)
      IDLE:  if (pending) state_nx = CLEAR;
      CLEAR: begin
        load = 1'b1;
        if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_nx = CHECK;
      end
      CHECK: begin
        if (pending)          state_nx = CLEAR;
        else if (remain_zero) state_nx = IDLE;
        else if (space_ok) begin
          state_nx = REQ;
          issue    = 1'b1;
        end
      end
      REQ: begin
        if (rd.Rd_Ack) begin
          advance  = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT:    if (rd.Rd_Done) state_nx = CHECK;
      default: state_nx = IDLE;
    endcase
  end

  // Request fields are captured on entry to REQ and held through the handshake.
  always_ff @(posedge ClkDisp or negedge Rst_n) begin
    if (!Rst_n) begin
      rd.Rd_Addr <= '0;
      rd.Rd_Len  <= '0;
    end else if (issue) begin
      rd.Rd_Addr <= addr;
      rd.Rd_Len  <= next_len;
    end
  end

  assign rd.Rd_Req  = (state == REQ);
  assign Fifo_Clr   = (state == CLEAR);
  assign Frame_Busy = (state != IDLE);

`ifdef DISP_UNDERRUN_CNT_EN
  always_ff @(posedge ClkDisp or negedge Rst_n) begin
    if (!Rst_n)                                        Underrun_Cnt <= '0;
    else if (state == CLEAR)                           Underrun_Cnt <= '0;
    else if (DataReq && Fifo_Empty && (Underrun_Cnt != '1)) Underrun_Cnt <= Underrun_Cnt + 16'd1;
  end
`else
  logic unused_underrun_inputs;
  assign unused_underrun_inputs = DataReq ^ Fifo_Empty;
`endif

endmodule

// File: tb/tb_disp_frame_rd_sched.sv
// Scoreboard bench for disp_frame_rd_sched: full-geometry instance A and a
// 100-word frame instance B at base 256; underrun test needs DISP_UNDERRUN_CNT_EN.
module tb_disp_frame_rd_sched;

  localparam int unsigned AW = 28;
  localparam int unsigned LW = 8;
  localparam int unsigned VW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } burst_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fb_a = 1'b0, fb_b = 1'b0;
  logic [VW-1:0] lvl_a = '0, lvl_b = '0;
  logic          empty_a = 1'b0, dreq_a = 1'b0;
  logic          clr_a, busy_a, clr_b, busy_b;
`ifdef DISP_UNDERRUN_CNT_EN
  logic [15:0]   ucnt_a, ucnt_b;
`endif

  burst_t qa[$];
  burst_t qb[$];
  int vectors = 0;
  int miscompares = 0;

  disp_frame_rd_sched_if #(.ADDR_W(AW), .LEN_W(LW)) ifa ();
  disp_frame_rd_sched_if #(.ADDR_W(AW), .LEN_W(LW)) ifb ();

  disp_frame_rd_sched #(
    .ADDR_W(AW), .BASE_ADDR(28'd0), .FRAME_WORDS(384000), .BURST_LEN(64),
    .LEN_W(LW), .FIFO_DEPTH(512), .LEVEL_W(VW), .CLR_CYCLES(4)
  ) dut_a (
    .ClkDisp(clk), .Rst_n(rst_n), .Frame_Begin(fb_a), .Fifo_Level(lvl_a),
    .Fifo_Empty(empty_a), .DataReq(dreq_a), .rd(ifa.master),
    .Fifo_Clr(clr_a), .Frame_Busy(busy_a)
`ifdef DISP_UNDERRUN_CNT_EN
    , .Underrun_Cnt(ucnt_a)
`endif
  );

  disp_frame_rd_sched #(
    .ADDR_W(AW), .BASE_ADDR(28'd256), .FRAME_WORDS(100), .BURST_LEN(64),
    .LEN_W(LW), .FIFO_DEPTH(512), .LEVEL_W(VW), .CLR_CYCLES(4)
  ) dut_b (
    .ClkDisp(clk), .Rst_n(rst_n), .Frame_Begin(fb_b), .Fifo_Level(lvl_b),
    .Fifo_Empty(1'b0), .DataReq(1'b0), .rd(ifb.master),
    .Fifo_Clr(clr_b), .Frame_Busy(busy_b)
`ifdef DISP_UNDERRUN_CNT_EN
    , .Underrun_Cnt(ucnt_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input bit to_b, input int unsigned base,
                            input int unsigned words, input int unsigned blen);
    int unsigned a, rem, n;
    burst_t b;
    a = base;
    rem = words;
    while (rem != 0) begin
      n = (rem < blen) ? rem : blen;
      b.addr = AW'(a);
      b.len  = LW'(n);
      if (to_b) qb.push_back(b);
      else      qa.push_back(b);
      a   += n;
      rem -= n;
    end
  endtask

  task automatic pulse_fb_a();
    fb_a = 1'b1;
    cyc();
    fb_a = 1'b0;
  endtask

  // Arbiter model for A: checks each request against the scoreboard, acks, signals done.
  task automatic serve_a(input int ack_dly, input int done_dly, input int nbursts);
    for (int k = 0; k < nbursts; k++) begin
      burst_t exp_b;
      int n;
      bit unstable;
      n = 0;
      unstable = 1'b0;
      exp_b.addr = '0;
      exp_b.len = '0;
      while (ifa.Rd_Req !== 1'b1 && n < 300) begin cyc(); n++; end
      vectors++;
      if (ifa.Rd_Req !== 1'b1) begin
        miscompares++;
        $display("FAIL req_timeout_a: Rd_Req=%b, required 1 within 300 cycles", ifa.Rd_Req);
        return;
      end
      vectors++;
      if (qa.size() == 0) begin
        miscompares++;
        $display("FAIL extra_burst_a: addr=%0d len=%0d, required no request", ifa.Rd_Addr, ifa.Rd_Len);
      end else begin
        exp_b = qa.pop_front();
        vectors++;
        if (ifa.Rd_Addr !== exp_b.addr) begin
          miscompares++;
          $display("FAIL rd_addr_a: got %0d required %0d", ifa.Rd_Addr, exp_b.addr);
        end
        vectors++;
        if (ifa.Rd_Len !== exp_b.len) begin
          miscompares++;
          $display("FAIL rd_len_a: got %0d required %0d", ifa.Rd_Len, exp_b.len);
        end
      end
      for (int d = 0; d < ack_dly; d++) begin
        cyc();
        if (ifa.Rd_Req !== 1'b1 || ifa.Rd_Addr !== exp_b.addr || ifa.Rd_Len !== exp_b.len)
          unstable = 1'b1;
      end
      if (ack_dly > 0) begin
        vectors++;
        if (unstable) begin
          miscompares++;
          $display("FAIL req_hold_a: req=%b addr=%0d len=%0d, required 1/%0d/%0d held",
                   ifa.Rd_Req, ifa.Rd_Addr, ifa.Rd_Len, exp_b.addr, exp_b.len);
        end
      end
      ifa.Rd_Ack = 1'b1;
      cyc();
      ifa.Rd_Ack = 1'b0;
      vectors++;
      if (ifa.Rd_Req !== 1'b0) begin
        miscompares++;
        $display("FAIL req_drop_a: Rd_Req=%b required 0 after ack", ifa.Rd_Req);
      end
      repeat (done_dly) cyc();
      ifa.Rd_Done = 1'b1;
      cyc();
      ifa.Rd_Done = 1'b0;
    end
  endtask

  task automatic test_reset();
    ifa.Rd_Ack = 1'b0; ifa.Rd_Done = 1'b0;
    ifb.Rd_Ack = 1'b0; ifb.Rd_Done = 1'b0;
    rst_n = 1'b0;
    repeat (3) cyc();
    vectors++;
    if ({ifa.Rd_Req, clr_a, busy_a, ifb.Rd_Req, clr_b, busy_b} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: req/clr/busy A,B=%b required 000000",
               {ifa.Rd_Req, clr_a, busy_a, ifb.Rd_Req, clr_b, busy_b});
    end
    vectors++;
    if (ifa.Rd_Addr !== '0 || ifa.Rd_Len !== '0) begin
      miscompares++;
      $display("FAIL reset_fields: addr=%0d len=%0d required 0/0", ifa.Rd_Addr, ifa.Rd_Len);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_full_frame();
    int clr_n, n;
    clr_n = 0;
    push_frame(1'b0, 0, 384000, 64);
    pulse_fb_a();
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (clr_a === 1'b1) clr_n++;
    end
    vectors++;
    if (clr_n != 4) begin
      miscompares++;
      $display("FAIL clr_width_full: Fifo_Clr high %0d cycles, required 4", clr_n);
    end
    vectors++;
    if (busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_full: Frame_Busy=%b required 1", busy_a);
    end
    serve_a(1, 64, 3);
    serve_a(0, 1, 5997);
    n = 0;
    while (busy_a !== 1'b0 && n < 10) begin cyc(); n++; end
    vectors++;
    if (busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_fall_full: Frame_Busy=%b required 0", busy_a);
    end
    vectors++;
    if (qa.size() != 0) begin
      miscompares++;
      $display("FAIL bursts_full: %0d bursts never requested, required 0", qa.size());
    end
  endtask

  task automatic test_short_frame();
    int n;
    bit bad;
    burst_t exp_b;
    push_frame(1'b1, 256, 100, 64);
    fb_b = 1'b1;
    cyc();
    fb_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (ifb.Rd_Req !== 1'b1 && n < 50) begin cyc(); n++; end
      vectors++;
      if (ifb.Rd_Req !== 1'b1 || qb.size() == 0) begin
        miscompares++;
        $display("FAIL req_b: Rd_Req=%b pending=%0d, required 1 with expected burst", ifb.Rd_Req, qb.size());
        return;
      end
      exp_b = qb.pop_front();
      vectors++;
      if (ifb.Rd_Addr !== exp_b.addr || ifb.Rd_Len !== exp_b.len) begin
        miscompares++;
        $display("FAIL burst_b: addr=%0d len=%0d required %0d/%0d",
                 ifb.Rd_Addr, ifb.Rd_Len, exp_b.addr, exp_b.len);
      end
      ifb.Rd_Ack = 1'b1; cyc(); ifb.Rd_Ack = 1'b0;
      repeat (3) cyc();
      ifb.Rd_Done = 1'b1; cyc(); ifb.Rd_Done = 1'b0;
    end
    n = 0;
    bad = 1'b0;
    while (busy_b !== 1'b0 && n < 10) begin
      if (ifb.Rd_Req === 1'b1) bad = 1'b1;
      cyc();
      n++;
    end
    vectors++;
    if (busy_b !== 1'b0 || bad) begin
      miscompares++;
      $display("FAIL end_b: Frame_Busy=%b extra_req=%b, required 0/0", busy_b, bad);
    end
    // Stray handshake strobes while idle must not start anything.
    ifb.Rd_Ack = 1'b1; ifb.Rd_Done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin ifb.Rd_Ack = 1'b0; ifb.Rd_Done = 1'b0; end
      cyc();
      if (ifb.Rd_Req !== 1'b0 || busy_b !== 1'b0 || clr_b !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL stray_b: req=%b busy=%b clr=%b, required 0/0/0", ifb.Rd_Req, busy_b, clr_b);
    end
  endtask

  task automatic test_ack_delay();
    push_frame(1'b0, 0, 384000, 64);
    pulse_fb_a();
    serve_a(10, 2, 1);
    serve_a(0, 1, 1);
  endtask

  task automatic test_restart_in_wait();
    int n, clr_n;
    bit early;
    burst_t exp_b;
    n = 0;
    clr_n = 0;
    early = 1'b0;
    while (ifa.Rd_Req !== 1'b1 && n < 50) begin cyc(); n++; end
    exp_b = qa.pop_front();
    vectors++;
    if (ifa.Rd_Req !== 1'b1 || ifa.Rd_Addr !== exp_b.addr) begin
      miscompares++;
      $display("FAIL restart_req: req=%b addr=%0d, required 1/%0d", ifa.Rd_Req, ifa.Rd_Addr, exp_b.addr);
    end
    ifa.Rd_Ack = 1'b1; cyc(); ifa.Rd_Ack = 1'b0;
    pulse_fb_a();
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (clr_a !== 1'b0 || ifa.Rd_Req !== 1'b0) early = 1'b1;
    end
    vectors++;
    if (early) begin
      miscompares++;
      $display("FAIL restart_early: clr=%b req=%b before Rd_Done, required 0/0", clr_a, ifa.Rd_Req);
    end
    ifa.Rd_Done = 1'b1; cyc(); ifa.Rd_Done = 1'b0;
    qa.delete();
    push_frame(1'b0, 0, 384000, 64);
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (clr_a === 1'b1) clr_n++;
    end
    vectors++;
    if (clr_n != 4) begin
      miscompares++;
      $display("FAIL clr_width_restart: Fifo_Clr high %0d cycles, required 4", clr_n);
    end
    serve_a(0, 1, 2);
  endtask

  task automatic test_level_gate();
    int n;
    bit bad;
    burst_t exp_b;
    n = 0;
    bad = 1'b0;
    while (ifa.Rd_Req !== 1'b1 && n < 50) begin cyc(); n++; end
    exp_b = qa.pop_front();
    vectors++;
    if (ifa.Rd_Req !== 1'b1 || ifa.Rd_Addr !== exp_b.addr) begin
      miscompares++;
      $display("FAIL level_pre: req=%b addr=%0d, required 1/%0d", ifa.Rd_Req, ifa.Rd_Addr, exp_b.addr);
    end
    lvl_a = 10'd449;
    ifa.Rd_Ack = 1'b1; cyc(); ifa.Rd_Ack = 1'b0;
    cyc();
    ifa.Rd_Done = 1'b1; cyc(); ifa.Rd_Done = 1'b0;
    for (int d = 0; d < 20; d++) begin
      if (d == 5) ifa.Rd_Ack = 1'b1;
      if (d == 6) begin ifa.Rd_Ack = 1'b0; ifa.Rd_Done = 1'b1; end
      if (d == 7) ifa.Rd_Done = 1'b0;
      cyc();
      if (ifa.Rd_Req !== 1'b0 || busy_a !== 1'b1) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL level_449: req=%b busy=%b, required 0/1 throughout", ifa.Rd_Req, busy_a);
    end
    lvl_a = 10'd448;
    cyc();
    exp_b = qa.pop_front();
    vectors++;
    if (ifa.Rd_Req !== 1'b1) begin
      miscompares++;
      $display("FAIL level_448: Rd_Req=%b required 1", ifa.Rd_Req);
    end
    vectors++;
    if (ifa.Rd_Addr !== exp_b.addr || ifa.Rd_Len !== exp_b.len) begin
      miscompares++;
      $display("FAIL level_burst: addr=%0d len=%0d required %0d/%0d",
               ifa.Rd_Addr, ifa.Rd_Len, exp_b.addr, exp_b.len);
    end
    lvl_a = '0;
  endtask

`ifdef DISP_UNDERRUN_CNT_EN
  task automatic test_underrun();
    int n;
    vectors++;
    if (ucnt_a !== 16'd0) begin
      miscompares++;
      $display("FAIL underrun_start: got %0d required 0", ucnt_a);
    end
    dreq_a = 1'b1; empty_a = 1'b1;
    repeat (5) cyc();
    dreq_a = 1'b0; empty_a = 1'b0;
    cyc();
    vectors++;
    if (ucnt_a !== 16'd5) begin
      miscompares++;
      $display("FAIL underrun_count: got %0d required 5", ucnt_a);
    end
    pulse_fb_a();
    ifa.Rd_Ack = 1'b1; cyc(); ifa.Rd_Ack = 1'b0;
    ifa.Rd_Done = 1'b1; cyc(); ifa.Rd_Done = 1'b0;
    n = 0;
    while (clr_a !== 1'b1 && n < 10) begin cyc(); n++; end
    cyc();
    vectors++;
    if (ucnt_a !== 16'd0) begin
      miscompares++;
      $display("FAIL underrun_clear: got %0d required 0", ucnt_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_ack_delay();
    test_restart_in_wait();
    test_level_gate();
`ifdef DISP_UNDERRUN_CNT_EN
    test_underrun();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
